vga_scan_ctrl: RTL and testbench
================================

// Module: vga_scan_ctrl
// PURPOSE
//  Scan controller for the PMOD VGA output: generates H/V timing, issues per-pixel fetch requests to the
//  PipelineC pixel source PIPE_LAT cycles ahead, and registers RGB444+sync onto the PMOD pins.
//  Runs on the PLL pixel clock; held idle until PLL lock. Sits between pll and the pixel datapath.
// PARAMETERS
//  H_ACTIVE  640  visible pixels/line
//  H_FP      16   h front porch (clocks)
//  H_SYNC    96   h sync width
//  H_BP      48   h back porch
//  V_ACTIVE  480  visible lines/frame
//  V_FP      10   v front porch (lines)
//  V_SYNC    2    v sync width
//  V_BP      33   v back porch
//  SYNC_POL  0    sync active level (0 = active-low)
//  PIPE_LAT  2    req_valid -> pix_valid latency of pixel source (1..8)
// PORTS
//  pll_clk     in   1   pixel clock (single clock domain)
//  rst         in   1   synchronous, active-high reset
//  pll_locked  in   1   PLL lock; low forces IDLE immediately
//  en          in   1   run request; deassert stops at end of frame
//  req_valid   out  1   fetch request for pixel (req_x, req_y)
//  req_x       out  10  column, 0..H_ACTIVE-1
//  req_y       out  10  row, 0..V_ACTIVE-1
//  frame_start out  1   1-cycle pulse with request for (0,0)
//  pix_valid   in   1   pixel data valid, PIPE_LAT cycles after req_valid
//  pix_rgb     in   12  {R[3:0],G[3:0],B[3:0]}
//  vga_rgb     out  12  registered pin RGB
//  vga_hs      out  1   registered h sync
//  vga_vs      out  1   registered v sync
//  underflow   out  1   sticky: expected pix_valid missing; cleared by rst or IDLE entry
// BEHAVIOUR
//  Reset: state IDLE, counters 0, req_valid/frame_start/underflow 0, vga_rgb 0, hs/vs = ~SYNC_POL.
//  States: IDLE -> RUN when pll_locked&&en; RUN -> STOP_PEND when !en; STOP_PEND -> IDLE at
//   h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1; STOP_PEND -> RUN if en reasserts before frame end.
//   Any state -> IDLE same cycle as !pll_locked (abort; delay pipe flushed, pins to reset values).
//  h_cnt 0..H_TOTAL-1 (H_TOTAL=sum of H_*), wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL.
//  Counters are the request timeline: active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; req_valid=active in RUN/STOP_PEND.
//  hs active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs likewise on v_cnt (whole lines).
//  Sync/active flags delayed PIPE_LAT stages; pin register one more: request at t -> pins at t+PIPE_LAT+1.
//  At delayed-active cycle: pix_valid=1 -> vga_rgb<=pix_rgb; pix_valid=0 -> vga_rgb<=0, underflow<=1.
//  pix_valid outside delayed-active is ignored (no error). Blanking: vga_rgb=0.
//  IDLE: counters held 0, no requests, pins at reset values; re-entering RUN restarts at (0,0).
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: extra input tp_sel(1); tp_sel=1 replaces pix_rgb with 8 vertical colour
//   bars (bar=req_x*8/H_ACTIVE, RGB bits {b2,b1,b0} each ->4'hF/0) and suppresses underflow; req_valid still driven.
//  Undefined: no tp_sel port, pixels only from pix_rgb.
// STRUCTURE
//  vga_ctrl_pkg: rgb444_t, scan_state_t {IDLE,RUN,STOP_PEND}, 640x480@60 timing localparams, COORD_W=10.
//  Sub-module vga_delay_line: PIPE_LAT-deep shift of {active,hs,vs}, sync clear on rst/abort.
// TESTING  (bench params H=8/2/4/2, V=4/1/2/1, PIPE_LAT=2 -> H_TOTAL 16, V_TOTAL 8)
//  rst released, pll_locked=1,en=1 -> frame_start at cycle 1 with req(0,0); first vga_rgb at cycle 4.
//  Source echoes pix_rgb=req_x*16+req_y -> pins show 12'h000..12'h073 sequence, hs low h_cnt 10..13, vs low v_cnt 5..6.
//  Drop pix_valid for pixel (3,1) -> that pin pixel 0, underflow=1 persists until IDLE entry.
//  Deassert en at (2,1) -> frame completes, IDLE after h15/v7, no req_valid thereafter.
//  Drop pll_locked mid-line -> next cycle req_valid=0, vga_rgb=0, hs=vs=1; relock restarts at (0,0).
//  VGA_TEST_PATTERN_EN, tp_sel=1, pix_valid=0 -> bars 000,00F,0F0,0FF,F00,F0F,FF0,FFF; underflow stays 0.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// VGA scan controller shared types, 640x480@60 timing defaults and
// colour-bar helpers used by the optional test pattern.
package vga_ctrl_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [11:0] rgb444_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_PEND
  } scan_state_t;

  function automatic logic [2:0] bar_idx(
    input logic [COORD_W-1:0] x,
    input int unsigned        h_act
  );
    int unsigned t;
    t = (32'(x) * 32'd8) / h_act;
    return t[2:0];
  endfunction

  function automatic rgb444_t bar_rgb(input logic [2:0] b);
    return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_delay.sv
// Fixed-depth shift of per-pixel timing flags so they line up with
// data returned by the pixel source; cleared synchronously.
module vga_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: H/V timeline, early pixel fetch, registered pins.
// Define VGA_TEST_PATTERN_EN to add tp_sel and the colour-bar generator.
module vga_scan_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_LAT = 2
) (
  input  logic               pll_clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               en,
  output logic               req_valid,
  output logic [COORD_W-1:0] req_x,
  output logic [COORD_W-1:0] req_y,
  output logic               frame_start,
  input  logic               pix_valid,
  input  rgb444_t            pix_rgb,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               tp_sel,
`endif
  output rgb444_t            vga_rgb,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  localparam logic               SP     = SYNC_POL;

  scan_state_t        r_state;
  scan_state_t        w_state_nxt;
  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic               w_frame_end;
  logic               w_run;
  logic               w_req;
  logic               w_hs_on;
  logic               w_vs_on;
  logic               w_d_act;
  logic               w_d_hs;
  logic               w_d_vs;
  logic               w_tp;
  rgb444_t            w_tp_rgb;
  rgb444_t            r_rgb;
  logic               r_hs;
  logic               r_vs;
  logic               r_uf;

  assign w_frame_end = (r_h == H_LAST) && (r_v == V_LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:      if (pll_locked && en) w_state_nxt = RUN;
      RUN:       if (!en) w_state_nxt = STOP_PEND;
      STOP_PEND: begin
        if (w_frame_end) w_state_nxt = IDLE;
        else if (en)     w_state_nxt = RUN;
      end
      default:   w_state_nxt = IDLE;
    endcase
    if (!pll_locked) w_state_nxt = IDLE;
  end

  always_ff @(posedge pll_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Counters sit at 0 while idle so a restart always begins at (0,0)
  always_ff @(posedge pll_clk) begin
    if (rst || r_state == IDLE || w_state_nxt == IDLE) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + ONE;
    end else begin
      r_h <= r_h + ONE;
    end
  end

  assign w_run   = (r_state != IDLE) && pll_locked;
  assign w_req   = w_run && (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_on = w_run && (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs_on = w_run && (r_v >= VS_BEG) && (r_v < VS_END);

  assign req_valid   = w_req;
  assign req_x       = w_req ? r_h : '0;
  assign req_y       = w_req ? r_v : '0;
  assign frame_start = w_run && (r_h == '0) && (r_v == '0);

`ifdef VGA_TEST_PATTERN_EN
  localparam int DW = 6;
  logic [DW-1:0] w_dl_in;
  logic [DW-1:0] w_dl_out;
  assign w_dl_in  = {bar_idx(r_h, H_ACTIVE), w_req, w_hs_on, w_vs_on};
  assign w_tp     = tp_sel;
  assign w_tp_rgb = bar_rgb(w_dl_out[5:3]);
`else
  localparam int DW = 3;
  logic [DW-1:0] w_dl_in;
  logic [DW-1:0] w_dl_out;
  assign w_dl_in  = {w_req, w_hs_on, w_vs_on};
  assign w_tp     = 1'b0;
  assign w_tp_rgb = '0;
`endif

  vga_delay_line #(
    .W     (DW),
    .DEPTH (PIPE_LAT)
  ) u_dly (
    .i_clk (pll_clk),
    .i_clr (rst || !pll_locked),
    .i_d   (w_dl_in),
    .o_q   (w_dl_out)
  );

  assign w_d_act = w_dl_out[2];
  assign w_d_hs  = w_dl_out[1];
  assign w_d_vs  = w_dl_out[0];

  always_ff @(posedge pll_clk) begin
    if (rst || !pll_locked) begin
      r_rgb <= '0;
      r_hs  <= ~SP;
      r_vs  <= ~SP;
    end else begin
      r_hs <= w_d_hs ? SP : ~SP;
      r_vs <= w_d_vs ? SP : ~SP;
      if (!w_d_act)       r_rgb <= '0;
      else if (w_tp)      r_rgb <= w_tp_rgb;
      else if (pix_valid) r_rgb <= pix_rgb;
      else                r_rgb <= '0;
    end
  end

  always_ff @(posedge pll_clk) begin
    if (rst || w_state_nxt == IDLE)            r_uf <= 1'b0;
    else if (w_d_act && !w_tp && !pix_valid) r_uf <= 1'b1;
  end

  assign vga_rgb   = r_rgb;
  assign vga_hs    = r_hs;
  assign vga_vs    = r_vs;
  assign underflow = r_uf;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a shrunken 16x8 raster with an
// echoing pixel source two cycles deep.
module tb_vga_scan_ctrl;
  import vga_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               pll_locked;
  logic               en;
  logic               req_valid;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic               frame_start;
  logic               pix_valid;
  rgb444_t            pix_rgb;
  rgb444_t            vga_rgb;
  logic               vga_hs;
  logic               vga_vs;
  logic               underflow;
`ifdef VGA_TEST_PATTERN_EN
  logic               tp_sel;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic    drop_arm = 1'b1;
  logic    mute     = 1'b0;
  logic    s1_v     = 1'b0;
  logic    s2_v     = 1'b0;
  rgb444_t s1_rgb   = '0;
  rgb444_t s2_rgb   = '0;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (4),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .SYNC_POL (1'b0),
    .PIPE_LAT (2)
  ) dut (
    .pll_clk     (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .en          (en),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_rgb     (pix_rgb),
`ifdef VGA_TEST_PATTERN_EN
    .tp_sel      (tp_sel),
`endif
    .vga_rgb     (vga_rgb),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .underflow   (underflow)
  );

  // Pixel source: echoes x*16+y two cycles after the request
  always @(posedge clk) begin
    s1_v   <= req_valid && !(drop_arm && req_x == 3 && req_y == 1);
    s1_rgb <= 12'(req_x) * 12'd16 + 12'(req_y);
    s2_v   <= s1_v;
    s2_rgb <= s1_rgb;
  end

  assign pix_valid = s2_v && !mute;
  assign pix_rgb   = s2_rgb;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [11:0] bars [8];

  initial begin
    bars = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
             12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
    rst        = 1'b1;
    pll_locked = 1'b1;
    en         = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    tp_sel     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst req_valid", req_valid, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst rgb", vga_rgb, 0);
    chk("rst hs", vga_hs, 1);
    chk("rst vs", vga_vs, 1);
    chk("rst underflow", underflow, 0);

    for (int c = 1; c <= 270; c++) begin
      int k, h, v, p, ph, pv;
      logic ev, efs, ehs, evs, euf;
      logic [11:0] erg;
      step();
      if (c <= 256) begin
        k   = c - 1;
        h   = k % 16;
        v   = (k / 16) % 8;
        ev  = (h < 8) && (v < 4);
        efs = (h == 0) && (v == 0);
      end else begin
        h = 0; v = 0; ev = 0; efs = 0;
      end
      chk($sformatf("req_valid c%0d", c), req_valid, ev);
      chk($sformatf("frame_start c%0d", c), frame_start, efs);
      if (ev) begin
        chk($sformatf("req_x c%0d", c), req_x, h);
        chk($sformatf("req_y c%0d", c), req_y, v);
      end
      p = c - 4;
      if (p >= 0 && p <= 255) begin
        ph  = p % 16;
        pv  = (p / 16) % 8;
        erg = (ph < 8 && pv < 4 && p != 19) ? 12'(ph * 16 + pv) : 12'h000;
        ehs = !(ph >= 10 && ph <= 13);
        evs = !(pv == 5 || pv == 6);
      end else begin
        erg = 12'h000; ehs = 1; evs = 1;
      end
      euf = (c >= 23) && (c <= 256);
      chk($sformatf("rgb c%0d", c), vga_rgb, erg);
      chk($sformatf("hs c%0d", c), vga_hs, ehs);
      chk($sformatf("vs c%0d", c), vga_vs, evs);
      chk($sformatf("underflow c%0d", c), underflow, euf);
      if (c == 100) drop_arm = 1'b0;
      if (c == 147) en = 1'b0;
      if (c == 270) en = 1'b1;
    end

    step();
    chk("restart frame_start", frame_start, 1);
    chk("restart req_x", req_x, 0);
    chk("restart req_y", req_y, 0);
    repeat (5) step();
    chk("pre-abort rgb", vga_rgb, 12'h020);
    pll_locked = 1'b0;
    #1;
    chk("abort req same cycle", req_valid, 0);
    step();
    chk("abort req_valid", req_valid, 0);
    chk("abort rgb", vga_rgb, 0);
    chk("abort hs", vga_hs, 1);
    chk("abort vs", vga_vs, 1);
    chk("abort underflow", underflow, 0);
    step();
    step();
    pll_locked = 1'b1;
    step();
    chk("relock frame_start", frame_start, 1);
    chk("relock req_valid", req_valid, 1);
    chk("relock req_x", req_x, 0);
    chk("relock req_y", req_y, 0);
    repeat (4) step();
    chk("relock rgb", vga_rgb, 12'h010);

`ifdef VGA_TEST_PATTERN_EN
    tp_sel = 1'b1;
    mute   = 1'b1;
`endif
    repeat (15) step();
    for (int i = 0; i < 8; i++) begin
`ifdef VGA_TEST_PATTERN_EN
      chk($sformatf("bar %0d", i), vga_rgb, bars[i]);
`else
      chk($sformatf("row1 px %0d", i), vga_rgb, 12'(i * 16 + 1));
`endif
      step();
    end
    chk("final underflow", underflow, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
